// File: rtl/avm_seq_ctrl.sv
// Sequential 8x8 multiplier controller: steps one external 4x4 unit through the
// LL/LH/HL/HH nibble products and shift-accumulates them. Optional AVM_ZERO_SKIP_EN.
module avm_seq_ctrl #(
    parameter int OPW   = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [OPW-1:0]     in_a,
    input  logic [OPW-1:0]     in_b,
    output logic               in_ready,
    output logic [OPW/2-1:0]   pm_a,
    output logic [OPW/2-1:0]   pm_b,
    output logic               pm_en,
    input  logic [OPW-1:0]     pm_p,
    output logic               out_valid,
    output logic [2*OPW-1:0]   out_p,
    input  logic               out_ready,
    output logic               busy,
    output logic [CNT_W-1:0]   op_cnt,
    output logic [1:0]         fsm_state
);
    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // in_ready is high only in IDLE and out_valid only in DONE.
    localparam int H = OPW / 2;

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

    state_t           state;
    logic [1:0]       step;
    logic [3:0]       mask;
    logic [OPW-1:0]   a_q;
    logic [OPW-1:0]   b_q;
    logic [2*OPW-1:0] acc;

    logic [3:0]       accept_mask;
    logic [2:0]       first;
    logic [2:0]       nxt;
    logic [2*OPW-1:0] term;

    // Returns the lowest enabled step index >= lo; bit 2 set means none remain.
    function automatic logic [2:0] find_from(input logic [3:0] m, input logic [2:0] lo);
        logic [2:0] r;
        r = 3'b100;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && i >= int'(lo)) r = {1'b0, 2'(i)};
        end
        return r;
    endfunction

    always_comb begin
`ifdef AVM_ZERO_SKIP_EN
        accept_mask[0] = (|in_a[H-1:0])   && (|in_b[H-1:0]);
        accept_mask[1] = (|in_a[H-1:0])   && (|in_b[OPW-1:H]);
        accept_mask[2] = (|in_a[OPW-1:H]) && (|in_b[H-1:0]);
        accept_mask[3] = (|in_a[OPW-1:H]) && (|in_b[OPW-1:H]);
`else
        accept_mask = 4'b1111;
`endif
        first = find_from(accept_mask, 3'd0);
        nxt   = find_from(mask, {1'b0, step} + 3'd1);
        // step bit 1 picks the high nibble of a, bit 0 the high nibble of b
        pm_a  = '0;
        pm_b  = '0;
        if (state == MUL) begin
            pm_a = step[1] ? a_q[OPW-1:H] : a_q[H-1:0];
            pm_b = step[0] ? b_q[OPW-1:H] : b_q[H-1:0];
        end
        case (step)
            2'd0:    term = (2*OPW)'(pm_p);
            2'd3:    term = (2*OPW)'(pm_p) << OPW;
            default: term = (2*OPW)'(pm_p) << H;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            step   <= 2'd0;
            mask   <= 4'b0;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            op_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q  <= in_a;
                        b_q  <= in_b;
                        acc  <= '0;
                        mask <= accept_mask;
                        if (first[2]) begin
                            state <= DONE;
                            step  <= 2'd0;
                        end else begin
                            state <= MUL;
                            step  <= first[1:0];
                        end
                    end
                end
                MUL: begin
                    acc <= acc + term;
                    if (nxt[2]) begin
                        state <= DONE;
                        step  <= 2'd0;
                    end else begin
                        step <= nxt[1:0];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state  <= IDLE;
                        op_cnt <= op_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign pm_en     = (state == MUL);
    assign out_p     = acc;
    assign fsm_state = state;

endmodule

// File: tb/tb_avm_seq_ctrl.sv
// Directed + random bench for avm_seq_ctrl with an exact 4x4 product model;
// latency expectations follow AVM_ZERO_SKIP_EN when it is defined.
module tb_avm_seq_ctrl;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_a = '0;
    logic [7:0]    in_b = '0;
    logic          in_ready;
    logic [3:0]    pm_a;
    logic [3:0]    pm_b;
    logic          pm_en;
    logic [7:0]    pm_p;
    logic          out_valid;
    logic [15:0]   out_p;
    logic          out_ready = 1'b0;
    logic          busy;
    logic [CW-1:0] op_cnt;
    logic [1:0]    fsm_state;

    int            total = 0;
    int            bad = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic [15:0]   exp_q[$];

    avm_seq_ctrl #(.OPW(8), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_ready(in_ready), .pm_a(pm_a), .pm_b(pm_b), .pm_en(pm_en), .pm_p(pm_p),
        .out_valid(out_valid), .out_p(out_p), .out_ready(out_ready), .busy(busy),
        .op_cnt(op_cnt), .fsm_state(fsm_state)
    );

    assign pm_p = {4'b0, pm_a} * {4'b0, pm_b};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 4;
`ifdef AVM_ZERO_SKIP_EN
        n = 0;
        if (a[3:0] != 0 && b[3:0] != 0) n++;
        if (a[3:0] != 0 && b[7:4] != 0) n++;
        if (a[7:4] != 0 && b[3:0] != 0) n++;
        if (a[7:4] != 0 && b[7:4] != 0) n++;
`endif
        return n;
    endfunction

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int hold);
        int n;
        int lat;
        logic [15:0] held;
        logic [15:0] exp;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_op", 32'(in_ready), 32'd1);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        exp_q.push_back({8'b0, a} * {8'b0, b});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        if (exp_lat(a, b) > 0) begin
            check("pm_en_in_mul", 32'(pm_en), 32'd1);
            check("busy_in_mul", 32'(busy), 32'd1);
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat(a, b)));
        held = out_p;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_stable", 32'(out_p), 32'(held));
            check("hold_not_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check("product", 32'(out_p), 32'(exp));
        out_ready = 1'b1;
        @(negedge clk);
        exp_cnt = exp_cnt + 1'b1;
        check("handoff_valid_low", 32'(out_valid), 32'd0);
        check("handoff_ready", 32'(in_ready), 32'd1);
        check("op_cnt", 32'(op_cnt), 32'(exp_cnt));
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_p", 32'(out_p), 32'd0);
        check("rst_pm_ab", 32'({pm_a, pm_b}), 32'd0);
        check("rst_pm_en", 32'(pm_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_cnt", 32'(op_cnt), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // reset in the middle of step 2 (HL) discards the operation
        in_a = 8'hAB;
        in_b = 8'hCD;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("step2_pm_a", 32'(pm_a), 32'hA);
        check("step2_pm_b", 32'(pm_b), 32'hD);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_pm_en", 32'(pm_en), 32'd0);
        check("midrst_pm_ab", 32'({pm_a, pm_b}), 32'd0);
        check("midrst_out_p", 32'(out_p), 32'd0);
        check("midrst_op_cnt", 32'(op_cnt), 32'(exp_cnt));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'hFF, 8'hFF, 0);
        do_op(8'h12, 8'h34, 0);
        do_op(8'hC3, 8'h5A, 10);
        do_op(8'h0F, 8'h0F, 0);
        do_op(8'h00, 8'h5A, 0);
        do_op(8'hF0, 8'h0F, 0);
        do_op(8'h00, 8'h00, 2);
        do_op(8'h01, 8'h80, 1);
        for (int k = 0; k < 20; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ra[3:0] = 4'h0;
            if ($urandom_range(0, 3) == 0) rb[7:4] = 4'h0;
            do_op(ra, rb, int'($urandom_range(0, 2)));
        end
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
